// File: rtl/code_change_controller.sv
// rtl/code_change_controller.sv - double-entry passcode change FSM feeding the stored code register
module code_change_controller #(
    parameter logic [15:0] SCRAMBLE_KEY   = 16'hA5C3,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        unlocked,
    input  logic        change_req,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        cancel,
    output logic        load,
    output logic [15:0] datain,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, ENTRY1, ENTRY2, COMMIT} state_t;

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    logic [15:0]   first, first_n;
    logic [15:0]   second, second_n;
    logic [1:0]    dcnt, dcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [15:0]   datain_n;
    logic          load_n, error_n;
    logic          digit_bad;

    assign digit_bad = digit_valid && (digit > 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            first  <= 16'h0000;
            second <= 16'h0000;
            dcnt   <= 2'd0;
            tcnt   <= '0;
            datain <= 16'h0000;
            load   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            first  <= first_n;
            second <= second_n;
            dcnt   <= dcnt_n;
            tcnt   <= tcnt_n;
            datain <= datain_n;
            load   <= load_n;
            done   <= load_n;
            error  <= error_n;
            busy   <= (state_n != IDLE);
        end
    end

    // Abort sources are checked in priority order: cancel, lost unlock, bad digit, then digit, then timeout.
    always_comb begin
        state_n  = state;
        first_n  = first;
        second_n = second;
        dcnt_n   = dcnt;
        tcnt_n   = tcnt;
        datain_n = datain;
        load_n   = 1'b0;
        error_n  = 1'b0;
        case (state)
            IDLE: begin
                if (change_req && unlocked) begin
                    state_n = ENTRY1;
                    dcnt_n  = 2'd0;
                    tcnt_n  = '0;
                end
            end
            ENTRY1, ENTRY2: begin
                if (cancel) begin
                    state_n = IDLE;
                end else if (!unlocked || digit_bad) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end else if (digit_valid) begin
                    tcnt_n = '0;
                    dcnt_n = dcnt + 2'd1;
                    if (state == ENTRY1) begin
                        first_n = {first[11:0], digit};
                        if (dcnt == 2'd3) begin
                            state_n = ENTRY2;
                        end
                    end else begin
                        second_n = {second[11:0], digit};
                        if (dcnt == 2'd3) begin
                            if (second_n == first) begin
                                state_n  = COMMIT;
                                datain_n = first ^ SCRAMBLE_KEY;
                                load_n   = 1'b1;
                            end else begin
                                state_n = IDLE;
                                error_n = 1'b1;
                            end
                        end
                    end
                end else if (tcnt == TMO_LAST) begin
                    state_n = IDLE;
                    error_n = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_code_change_controller.sv
// tb/tb_code_change_controller.sv - scoreboard bench for code_change_controller
module tb_code_change_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        unlocked = 1'b0;
    logic        change_req = 1'b0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        cancel = 1'b0;
    logic        load, busy, done, error;
    logic [15:0] datain;

    code_change_controller #(.SCRAMBLE_KEY(16'hA5C3), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .unlocked(unlocked), .change_req(change_req),
        .digit_valid(digit_valid), .digit(digit), .cancel(cancel),
        .load(load), .datain(datain), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [15:0] data;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] model_datain = 16'h0000;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(bit cr, bit dv, logic [3:0] d, bit cn);
        change_req  = cr;
        digit_valid = dv;
        digit       = d;
        cancel      = cn;
        @(posedge clk);
        #1;
        change_req  = 1'b0;
        digit_valid = 1'b0;
        cancel      = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic enter(logic [15:0] code, int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, code[15-4*i -: 4], 1'b0);
    endtask

    // Called just before the step whose sampling edge should produce the event.
    task automatic expect_load(logic [15:0] scrambled);
        model_datain = scrambled;
        sb.push_back('{1'b0, scrambled, cyc + 1});
    endtask

    task automatic expect_err();
        sb.push_back('{1'b1, model_datain, cyc + 1});
    endtask

    task automatic mon();
        exp_t e;
        if (rst) return;
        if (load || done) check("done_eq_load", 32'(done), 32'(load));
        if (load || error) begin
            check("load_error_exclusive", 32'(load & error), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({load, error}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", 32'(error), 32'(e.is_err));
                check("event_cycle", 32'(cyc), 32'(e.edge_no));
                check("event_datain", 32'(datain), 32'(e.data));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none

        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_load", 32'(load), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_datain", 32'(datain), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // change_req while locked
        step(1'b1, 1'b0, 4'd0, 1'b0);
        check("locked_req_busy", 32'(busy), 32'd0);
        unlocked = 1'b1;

        // mismatch
        step(1'b1, 1'b0, 4'd0, 1'b0);
        enter(16'h1234, 4);
        enter(16'h1235, 3);
        expect_err();
        step(1'b0, 1'b1, 4'h5, 1'b0);
        check("mismatch_busy", 32'(busy), 32'd0);

        // happy path
        step(1'b1, 1'b0, 4'd0, 1'b0);
        enter(16'h1234, 4);
        enter(16'h1234, 3);
        expect_load(16'hB7F7);
        step(1'b0, 1'b1, 4'h4, 1'b0);
        check("commit_busy", 32'(busy), 32'd1);
        idle(1);
        check("after_commit_busy", 32'(busy), 32'd0);

        // invalid digit, started on the first IDLE cycle after COMMIT
        step(1'b1, 1'b0, 4'd0, 1'b0);
        check("restart_busy", 32'(busy), 32'd1);
        expect_err();
        step(1'b0, 1'b1, 4'hC, 1'b0);
        check("bad_digit_busy", 32'(busy), 32'd0);

        // timeout
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0);
        idle(15);
        expect_err();
        idle(1);
        check("timeout_busy", 32'(busy), 32'd0);

        // digit on the expiry cycle is accepted; cancel beats timeout
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'h7, 1'b0);
        idle(15);
        step(1'b0, 1'b1, 4'h8, 1'b0);
        idle(15);
        check("expiry_digit_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 4'd0, 1'b1);
        check("cancel_on_expiry_busy", 32'(busy), 32'd0);

        // cancel with a digit in ENTRY2
        step(1'b1, 1'b0, 4'd0, 1'b0);
        enter(16'h1234, 4);
        enter(16'h1234, 2);
        step(1'b0, 1'b1, 4'h3, 1'b1);
        check("cancel_busy", 32'(busy), 32'd0);
        idle(2);

        // lost unlock in ENTRY1
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'h1, 1'b0);
        unlocked = 1'b0;
        expect_err();
        idle(1);
        unlocked = 1'b1;
        check("unlock_drop_busy", 32'(busy), 32'd0);

        // change_req while busy is ignored; unlock drop in COMMIT is harmless
        step(1'b1, 1'b0, 4'd0, 1'b0);
        enter(16'h5678, 2);
        step(1'b1, 1'b1, 4'h7, 1'b0);
        step(1'b0, 1'b1, 4'h8, 1'b0);
        enter(16'h5678, 3);
        expect_load(16'hF3BB);
        step(1'b0, 1'b1, 4'h8, 1'b0);
        unlocked = 1'b0;
        idle(1);
        unlocked = 1'b1;
        check("busy_req_commit_busy", 32'(busy), 32'd0);

        // asynchronous reset during COMMIT, after the monitor has seen load
        step(1'b1, 1'b0, 4'd0, 1'b0);
        enter(16'h9999, 4);
        enter(16'h9999, 3);
        expect_load(16'h3C5A);
        step(1'b0, 1'b1, 4'h9, 1'b0);
        #6;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_load", 32'(load), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_error", 32'(error), 32'd0);
        check("async_rst_datain", 32'(datain), 32'h0);
        model_datain = 16'h0000;
        #3;
        rst = 1'b0;
        idle(5);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_change_controller.md
# code_change_controller

- Upstream feeder of the stored code register.
- Lets an already-unlocked user enter a new 4-digit passcode twice. When both entries match, it scrambles the code and issues a single-cycle `load` with `datain` for the register to capture.
- Sits between the keypad digit decoder and the stored code register. Its `unlocked` input comes from the lock FSM.

## Interface
- `SCRAMBLE_KEY`, default 16'hA5C3: XOR key applied to the packed BCD code before it is driven on `datain`.
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between accepted digits before the change is aborted; must be ≥ 2.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `unlocked`  input  1  level; safe currently unlocked, so code change is permitted.
- `change_req`  input  1  pulse; start a code change.
- `digit_valid`  input  1  pulse; `digit` is valid this cycle.
- `digit`  input  4  BCD digit 0–9.
- `cancel`  input  1  pulse; abandon the change in progress.
- `load`  output  1  one-cycle pulse; register captures `datain`.
- `datain`  output  16  scrambled new passcode (registered).
- `busy`  output  1  high while in ENTRY1, ENTRY2 or COMMIT.
- `done`  output  1  one-cycle pulse, coincident with `load`.
- `error`  output  1  one-cycle pulse on any abort other than `cancel`.

## Operation
- **States:** IDLE, ENTRY1, ENTRY2, COMMIT.
- **IDLE:**
  - `change_req`=1 and `unlocked`=1 → ENTRY1; clear digit count and timeout counter.
  - Otherwise `change_req` is ignored, including whenever `busy`=1.
- **ENTRY1:**
  - Each `digit_valid` with `digit`≤9 shifts the digit into `first[15:0]`. First digit lands in [15:12], fourth in [3:0].
  - After the 4th digit → ENTRY2; count cleared.
- **ENTRY2:**
  - Same shifting into `second[15:0]`.
  - After the 4th digit: if `second`==`first` → COMMIT; else pulse `error` → IDLE.
- **COMMIT (one cycle):**
  - `datain` <= `first` ^ `SCRAMBLE_KEY`.
  - `load`=1, `done`=1.
  - → IDLE.
- **Invalid digit:** `digit_valid` with `digit`>9 in ENTRY1/ENTRY2 pulses `error` → IDLE.
- **Timeout:** counter increments every cycle in ENTRY1/ENTRY2 and clears on each accepted digit. Reaching `TIMEOUT_CYCLES`-1 with no digit that cycle pulses `error` → IDLE.
- **Lost unlock:** `unlocked`=0 in ENTRY1/ENTRY2 pulses `error` → IDLE. In COMMIT it has no effect; the commit completes.
- **Cancel:** `cancel` in ENTRY1/ENTRY2 → IDLE, no `error`, no `load`. Ignored in IDLE and COMMIT.
- **Priority within a cycle:** `cancel` > `unlocked` drop > invalid digit > valid digit > timeout.
  - A valid digit on the timeout cycle is accepted and clears the counter.
- **Register retention:** `first`, `second` and `datain` are not cleared on abort. `datain` holds its last committed value until the next COMMIT.

## Timing
- **Reset values:** state IDLE, `load`=0, `done`=0, `error`=0, `busy`=0, `datain`=16'h0000, counters 0.
- **Asynchronous reset:** `rst` immediately forces all outputs to their reset values, including mid-entry or during COMMIT. No `load` or `error` is produced by the reset.
- **Outputs are registered:**
  - `busy` rises the cycle after an accepted `change_req`.
  - `load`/`done`/`datain` are valid in the cycle after the edge that samples the 8th valid digit (1-cycle latency).
  - `error` is high the cycle after the sampling edge of the aborting condition.
- `load` and `done` are never high for more than one consecutive cycle. `error` and `load` are never high together.
- **Back-to-back digits:** `digit_valid` may be high on consecutive cycles; each is accepted.
- **Next change:** a new `change_req` is accepted on the first IDLE cycle after COMMIT or an abort.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs 0 asynchronously. Release, then idle 5 cycles → no pulses.
- **Happy path:**
  - Stimulus: `unlocked`=1, `change_req`, digits 1,2,3,4, then 1,2,3,4.
  - Response: one `load`+`done` pulse, `datain`=16'hB7F7, `busy` low the next cycle.
- **Mismatch:**
  - Stimulus: 1,2,3,4 then 1,2,3,5.
  - Response: one `error` pulse, no `load`, `datain` unchanged at 16'h0000.
- **Timeout (`TIMEOUT_CYCLES`=16):**
  - Stimulus: `change_req`, digit 7, then 16 idle cycles.
  - Response: `error` after the counter reaches 15, IDLE.
  - Variant: a digit on the expiry cycle → accepted, no `error`.
- **Cancel and lost unlock:**
  - `cancel` with a digit in the same cycle of ENTRY2 → IDLE, no `error`, no `load`.
  - A separate run dropping `unlocked` during ENTRY1 → one `error`.
- **Invalid inputs:**
  - Digit 4'hC in ENTRY1 → `error`.
  - `change_req` with `unlocked`=0 → stays IDLE, `busy`=0.
  - `change_req` while `busy` → ignored; the entry continues to a correct commit.
